// File: rtl/memory_address_sequencer.sv
// Memory address sequencer: a loadable address register that can also step
// through a strided burst. Each burst beat is offered on address_out with a
// valid/ready handshake. Addresses can optionally wrap inside an inclusive
// [wrap_base, wrap_limit] window.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   load, address_in  direct load of the address register (IDLE only)
//   start, burst_len  begin a burst of burst_len beats (IDLE only, 1..MAX_BURST)
//   stride            unsigned per-beat increment, zero-extended
//   wrap_en, wrap_base, wrap_limit   window wrap controls, latched at start
//   addr_ready        memory accepts the current beat
//   address_out       current address register
//   addr_valid, busy  high throughout BURST
//   done              one-cycle pulse after the final beat is accepted
module memory_address_sequencer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STRIDE_WIDTH = 8,
    parameter int unsigned MAX_BURST    = 16,
    localparam int unsigned CW          = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   address_in,
    input  logic                    start,
    input  logic [CW-1:0]           burst_len,
    input  logic [STRIDE_WIDTH-1:0] stride,
    input  logic                    wrap_en,
    input  logic [DATA_WIDTH-1:0]   wrap_base,
    input  logic [DATA_WIDTH-1:0]   wrap_limit,
    input  logic                    addr_ready,
    output logic [DATA_WIDTH-1:0]   address_out,
    output logic                    addr_valid,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   address_q;
    logic [CW-1:0]           count_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic                    wrap_en_q;
    logic [DATA_WIDTH-1:0]   base_q;
    logic [DATA_WIDTH-1:0]   limit_q;
    logic                    done_q;

    logic                    len_legal;
    logic                    start_ok;
    logic                    accept;
    logic                    last_beat;
    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH-1:0]   next_addr;

    assign len_legal = (burst_len != '0) && (burst_len <= CW'(MAX_BURST));
    assign start_ok  = (state_q == StIdle) && start && len_legal;
    assign accept    = (state_q == StBurst) && addr_ready;
    assign last_beat = accept && (count_q == CW'(1));

    // Extra top bit captures the carry so a wrap-around of the full address
    // space also counts as leaving the window.
    assign sum_ext = {1'b0, address_q} + {1'b0, DATA_WIDTH'(stride_q)};

    always_comb begin
        next_addr = sum_ext[DATA_WIDTH-1:0];
        if (wrap_en_q && (sum_ext[DATA_WIDTH] || (sum_ext[DATA_WIDTH-1:0] > limit_q))) begin
            next_addr = base_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok)  state_d = StBurst;
            StBurst: if (last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        addr_valid = 1'b0;
        busy       = 1'b0;
        if (state_q == StBurst) begin
            addr_valid = 1'b1;
            busy       = 1'b1;
        end
    end

    // Datapath: address, beat counter and burst configuration
    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= '0;
            count_q   <= '0;
            stride_q  <= '0;
            wrap_en_q <= 1'b0;
            base_q    <= '0;
            limit_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_beat;
            if (state_q == StIdle) begin
                // A simultaneous load means the burst starts from address_in.
                if (load) begin
                    address_q <= address_in;
                end
                if (start_ok) begin
                    count_q   <= burst_len;
                    stride_q  <= stride;
                    wrap_en_q <= wrap_en;
                    base_q    <= wrap_base;
                    limit_q   <= wrap_limit;
                end
            end else if (accept) begin
                address_q <= next_addr;
                count_q   <= count_q - CW'(1);
            end
        end
    end

    assign address_out = address_q;
    assign done        = done_q;

endmodule

// File: tb/tb_memory_address_sequencer.sv
module tb_memory_address_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;
    localparam int unsigned MB = 16;
    localparam int unsigned CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [DW-1:0] address_in;
    logic          start;
    logic [CW-1:0] burst_len;
    logic [SW-1:0] stride;
    logic          wrap_en;
    logic [DW-1:0] wrap_base;
    logic [DW-1:0] wrap_limit;
    logic          addr_ready;
    logic [DW-1:0] address_out;
    logic          addr_valid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    memory_address_sequencer #(
        .DATA_WIDTH  (DW),
        .STRIDE_WIDTH(SW),
        .MAX_BURST   (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .address_in (address_in),
        .start      (start),
        .burst_len  (burst_len),
        .stride     (stride),
        .wrap_en    (wrap_en),
        .wrap_base  (wrap_base),
        .wrap_limit (wrap_limit),
        .addr_ready (addr_ready),
        .address_out(address_out),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Check address plus the three status outputs in one go.
    task automatic check_all(input string tag, input logic [31:0] a, input logic v,
                             input logic b, input logic d);
        check({tag, ".addr"}, address_out, a);
        check({tag, ".valid"}, {31'd0, addr_valid}, {31'd0, v});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic do_load(input logic [31:0] a);
        load = 1'b1; address_in = a;
        step();
        load = 1'b0;
    endtask

    task automatic do_start(input int len, input int s, input logic we,
                            input logic [31:0] b, input logic [31:0] l);
        start = 1'b1; burst_len = CW'(len); stride = SW'(s);
        wrap_en = we; wrap_base = b; wrap_limit = l;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; address_in = '0; start = 1'b0; burst_len = '0;
        stride = '0; wrap_en = 1'b0; wrap_base = '0; wrap_limit = '0; addr_ready = 1'b1;
        #1;
        step();
        reset = 1'b0;
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        // Direct load
        do_load(32'h0000_ABCD);
        check_all("load", 32'h0000_ABCD, 1'b0, 1'b0, 1'b0);

        // Plain burst at full throughput
        do_load(32'h1000);
        do_start(4, 4, 1'b0, 32'h0, 32'h0);
        check_all("plain.b0", 32'h1000, 1'b1, 1'b1, 1'b0);
        step(); check_all("plain.b1", 32'h1004, 1'b1, 1'b1, 1'b0);
        step(); check_all("plain.b2", 32'h1008, 1'b1, 1'b1, 1'b0);
        step(); check_all("plain.b3", 32'h100C, 1'b1, 1'b1, 1'b0);
        step(); check_all("plain.done", 32'h1010, 1'b0, 1'b0, 1'b1);
        step(); check_all("plain.after", 32'h1010, 1'b0, 1'b0, 1'b0);

        // Back-pressure on the second beat for two cycles
        do_load(32'h1000);
        do_start(4, 4, 1'b0, 32'h0, 32'h0);
        check_all("bp.b0", 32'h1000, 1'b1, 1'b1, 1'b0);
        step();
        addr_ready = 1'b0;
        check_all("bp.hold0", 32'h1004, 1'b1, 1'b1, 1'b0);
        step(); check_all("bp.hold1", 32'h1004, 1'b1, 1'b1, 1'b0);
        step();
        addr_ready = 1'b1;
        check_all("bp.b1", 32'h1004, 1'b1, 1'b1, 1'b0);
        step(); check_all("bp.b2", 32'h1008, 1'b1, 1'b1, 1'b0);
        step(); check_all("bp.b3", 32'h100C, 1'b1, 1'b1, 1'b0);
        step(); check_all("bp.done", 32'h1010, 1'b0, 1'b0, 1'b1);

        // Wrap inside [0x100, 0x10F]
        do_load(32'h108);
        do_start(4, 4, 1'b1, 32'h100, 32'h10F);
        check_all("wrap.b0", 32'h108, 1'b1, 1'b1, 1'b0);
        step(); check_all("wrap.b1", 32'h10C, 1'b1, 1'b1, 1'b0);
        step(); check_all("wrap.b2", 32'h100, 1'b1, 1'b1, 1'b0);
        step(); check_all("wrap.b3", 32'h104, 1'b1, 1'b1, 1'b0);
        step(); check_all("wrap.done", 32'h108, 1'b0, 1'b0, 1'b1);

        // Carry out of the address space forces a wrap even though sum <= limit
        do_load(32'hFFFF_FFFC);
        do_start(2, 8, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        check_all("carry.b0", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        step(); check_all("carry.b1", 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
        step(); check_all("carry.done", 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1);

        // Load and start are ignored during a burst
        do_load(32'h1000);
        do_start(4, 4, 1'b0, 32'h0, 32'h0);
        step();
        load = 1'b1; address_in = 32'hDEAD_BEEF; start = 1'b1; burst_len = CW'(2);
        check_all("ign.b1", 32'h1004, 1'b1, 1'b1, 1'b0);
        step();
        load = 1'b0; start = 1'b0;
        check_all("ign.b2", 32'h1008, 1'b1, 1'b1, 1'b0);
        step(); check_all("ign.b3", 32'h100C, 1'b1, 1'b1, 1'b0);
        step(); check_all("ign.done", 32'h1010, 1'b0, 1'b0, 1'b1);

        // Illegal burst lengths leave the sequencer idle
        do_start(0, 4, 1'b0, 32'h0, 32'h0);
        check_all("len0", 32'h1010, 1'b0, 1'b0, 1'b0);
        do_start(17, 4, 1'b0, 32'h0, 32'h0);
        check_all("len17", 32'h1010, 1'b0, 1'b0, 1'b0);

        // Load and start together: burst begins at address_in
        load = 1'b1; address_in = 32'h2000;
        do_start(1, 4, 1'b0, 32'h0, 32'h0);
        load = 1'b0;
        check_all("ldst.b0", 32'h2000, 1'b1, 1'b1, 1'b0);
        step(); check_all("ldst.done", 32'h2004, 1'b0, 1'b0, 1'b1);

        // Zero stride repeats the address; full-length burst boundary
        do_start(16, 0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("s0.addr", address_out, 32'h2004);
            check("s0.valid", {31'd0, addr_valid}, 32'd1);
            step();
        end
        check_all("s0.done", 32'h2004, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a burst
        do_load(32'h1000);
        do_start(4, 4, 1'b0, 32'h0, 32'h0);
        step();
        check_all("rst.b1", 32'h1004, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all("rst.now", 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check_all("rst.after", 32'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/memory_address_sequencer.md
Name: memory_address_sequencer

Overview:
Parametrised successor to the single-register MAR. It holds a memory address, loads it directly, and also runs strided burst sequences with a valid/ready handshake towards the memory interface. Addresses can optionally wrap inside a programmable [base, limit] window. It sits between the control unit / DMA logic and the memory port, and replaces the plain MAR where sequential or circular-buffer access is needed.

Parameters:
DATA_WIDTH, 32, width of every address and window bound.
STRIDE_WIDTH, 8, width of the unsigned stride; zero-extended to DATA_WIDTH.
MAX_BURST, 16, largest legal burst length; CW = $clog2(MAX_BURST+1).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  load address_in into address register (IDLE only)
address_in  input  DATA_WIDTH  address to load
start  input  1  begin burst (IDLE only)
burst_len  input  CW  beats in burst; 0 or >MAX_BURST means start is ignored
stride  input  STRIDE_WIDTH  increment per beat
wrap_en  input  1  enable window wrap
wrap_base  input  DATA_WIDTH  window lower bound
wrap_limit  input  DATA_WIDTH  window upper bound, inclusive
addr_ready  input  1  memory accepts current address
address_out  output  DATA_WIDTH  current address register
addr_valid  output  1  address_out is a live burst beat
busy  output  1  high while in BURST
done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (synchronous): address_out=0, addr_valid=0, busy=0, done=0, beat counter=0, state=IDLE. Reset overrides all other inputs, including mid-burst; the burst is abandoned and no done pulse is produced.
- States: IDLE, BURST.
- IDLE:
  - load=1: address_out <= address_in on the next edge.
  - start=1 with a legal burst_len: latch stride, wrap_en, wrap_base, wrap_limit and burst_len; go to BURST next cycle.
  - load and start in the same cycle: the burst begins from address_in.
  - Illegal burst_len: start is ignored and the state stays IDLE.
- BURST:
  - addr_valid=busy=1 combinationally from state.
  - Beat accepted when addr_valid and addr_ready are both high. On acceptance, address_out <= next and counter decrements.
  - On acceptance of the final beat (counter==1): return to IDLE; done=1 for exactly the following cycle; address_out then points one stride past the last beat.
  - addr_ready low: address_out and counter hold; addr_valid stays high (no retraction).
  - load and start are ignored in BURST.
- Next-address arithmetic:
  - sum = address_out + zero-extended stride, modulo 2^DATA_WIDTH.
  - If latched wrap_en=1 and (sum > wrap_limit or the addition carried out), next = wrap_base; otherwise next = sum.
  - wrap_base > wrap_limit is undefined use; no checking is required.
- Latency: first beat is presented 1 cycle after start. At full throughput, N beats occupy N cycles, with done in cycle N+1.
- stride=0 is legal: the same address is repeated N times.

Test Plan:
- Reset then load: reset=1 for 1 cycle; load=1, address_in=0x0000ABCD -> address_out=0x0000ABCD next edge; addr_valid=busy=done=0 throughout.
- Plain burst: address_out=0x1000, start, burst_len=4, stride=4, addr_ready=1 -> beats 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; done pulse 1 cycle later; address_out=0x1010 after.
- Back-pressure: same burst with addr_ready low on cycles 2-3 -> 0x1004 is held with addr_valid=1 until ready; exactly 4 accepted beats; done follows the 4th acceptance.
- Wrap window: base=0x100, limit=0x10F, address_out=0x108, stride=4, len=4, wrap_en=1 -> beats 0x108, 0x10C, 0x100, 0x104; final address_out=0x108.
- Ignored controls: during BURST, pulse load with 0xDEADBEEF and start -> sequence unaffected. In IDLE, start with burst_len=0 -> busy stays 0. load+start same cycle with address_in=0x2000 -> first beat 0x2000.
- Reset mid-burst: assert reset on beat 2 of a 4-beat burst -> next cycle address_out=0, busy=addr_valid=0; done never pulses.
